// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framing state type and small helpers for the GMII
// transmit path (and the future receive checker).
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned MIN_PAYLOAD   = 46;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned HEADER_LEN    = 14;
  localparam int unsigned FCS_LEN       = 4;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  // Residue in MSB-first (non-reflected) form; an LSB-first register holds its bit reverse.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
  // 0x04C11DB7 bit-reversed, for the LSB-first shift used on the wire.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StHeader,
    StPayload,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

  // Zero bytes needed to lift a short payload to the 46-byte minimum.
  function automatic int unsigned pad_len(input int unsigned payload_len);
    return (payload_len < MIN_PAYLOAD) ? (MIN_PAYLOAD - payload_len) : 0;
  endfunction

endpackage

// File: rtl/eth_gmii_frame_gen_if.sv
// Control/status and GMII transmit bundle of the frame generator.
// master: control logic side; slave: the generator itself.
interface eth_gmii_frame_gen_if;

  logic        start;
  logic        continuous;
  logic        busy;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic [15:0] frames_sent;

  modport master (
    output start,
    output continuous,
    input  busy,
    input  gmii_tx_en,
    input  gmii_txd,
    input  frames_sent
  );

  modport slave (
    input  start,
    input  continuous,
    output busy,
    output gmii_tx_en,
    output gmii_txd,
    output frames_sent
  );

endinterface

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (802.3) advance by one byte. The register is kept in
// LSB-first form, data bit 0 is consumed first, matching GMII bit order.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_next
);

  logic [31:0] w_acc;

  // Eight serial shift steps unrolled into one cycle.
  always_comb begin
    w_acc = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0] ^ i_data[i]) begin
        w_acc = (w_acc >> 1) ^ CRC_POLY_REFL;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
  end

  assign o_next = w_acc;

endmodule

// File: rtl/eth_gmii_frame_gen.sv
// GMII Ethernet frame generator: preamble, SFD, MAC header, sequence-numbered
// payload, zero pad, CRC-32 FCS and inter-frame gap, single-shot or continuous.
// r_state/r_cnt describe the byte currently on gmii_txd; outputs are registered
// from the next-state decode so the first preamble byte follows start by one cycle.
module eth_gmii_frame_gen
  import eth_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h0012_3456_789A,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int unsigned PAYLOAD_LEN = 46,
  parameter int unsigned IFG_CYCLES  = 12
) (
  input  logic          clock,
  input  logic          reset_n,
  eth_gmii_frame_gen_if.slave bus
);

  localparam int unsigned PAD_LEN       = pad_len(PAYLOAD_LEN);
  localparam logic [10:0] PREAMBLE_LAST = 11'(PREAMBLE_LEN - 1);
  localparam logic [10:0] HEADER_LAST   = 11'(HEADER_LEN - 1);
  localparam logic [10:0] PAYLOAD_LAST  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0] PAD_LAST      = 11'(PAD_LEN - 1);
  localparam logic [10:0] FCS_LAST      = 11'(FCS_LEN - 1);
  localparam logic [10:0] IFG_LAST      = 11'(IFG_CYCLES - 1);
  localparam logic [111:0] HEADER       = {DST_MAC, SRC_MAC, ETHERTYPE};

  tx_state_e   r_state;
  tx_state_e   w_state_d;
  logic [10:0] r_cnt;
  logic [10:0] w_cnt_d;
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;
  logic [31:0] w_crc_fcs;
  logic        w_in_data;
  logic        r_tx_en;
  logic        w_tx_en_d;
  logic [7:0]  r_txd;
  logic [7:0]  w_txd_d;
  logic        r_busy;
  logic [15:0] r_frames;
  logic [15:0] w_frames_d;
  logic [6:0]  w_hdr_lo;
  logic [4:0]  w_fcs_lo;

  // The byte on the wire is covered by the CRC while in header/payload/pad.
  assign w_in_data = (r_state == StHeader) || (r_state == StPayload) || (r_state == StPad);

  crc32_d8 u_crc32_d8 (
    .i_crc  (r_crc),
    .i_data (r_txd),
    .o_next (w_crc_next)
  );

  // On entry to FCS the last data byte is still being folded in, so use the
  // advanced value; during FCS the register is frozen at the final CRC.
  assign w_crc_fcs = w_in_data ? w_crc_next : r_crc;

  // Next-state decode; every state entry restarts the byte counter.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start || bus.continuous) w_state_d = StPreamble;
      end
      StPreamble: begin
        if (r_cnt == PREAMBLE_LAST) w_state_d = StSfd;
      end
      StSfd: begin
        w_state_d = StHeader;
      end
      StHeader: begin
        if (r_cnt == HEADER_LAST) w_state_d = StPayload;
      end
      StPayload: begin
        if (r_cnt == PAYLOAD_LAST) w_state_d = (PAD_LEN != 0) ? StPad : StFcs;
      end
      StPad: begin
        if (r_cnt == PAD_LAST) w_state_d = StFcs;
      end
      StFcs: begin
        if (r_cnt == FCS_LAST) w_state_d = StIfg;
      end
      StIfg: begin
        if (r_cnt == IFG_LAST) w_state_d = bus.continuous ? StPreamble : StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    // No state loops back to itself, so a change of state means a fresh entry.
    w_cnt_d = ((w_state_d == r_state) && (r_state != StIdle)) ? (r_cnt + 11'd1) : 11'd0;
  end

  // Frame counter advances on the last FCS byte.
  always_comb begin
    w_frames_d = r_frames;
    if ((r_state == StFcs) && (r_cnt == FCS_LAST)) w_frames_d = r_frames + 16'd1;
  end

  // Byte to present next cycle, decoded from the next state and counter.
  always_comb begin
    w_tx_en_d = 1'b0;
    w_txd_d   = 8'h00;
    w_hdr_lo  = 7'd104 - {w_cnt_d[3:0], 3'b000};
    w_fcs_lo  = {w_cnt_d[1:0], 3'b000};
    unique case (w_state_d)
      StPreamble: begin
        w_tx_en_d = 1'b1;
        w_txd_d   = PREAMBLE_BYTE;
      end
      StSfd: begin
        w_tx_en_d = 1'b1;
        w_txd_d   = SFD_BYTE;
      end
      StHeader: begin
        w_tx_en_d = 1'b1;
        w_txd_d   = HEADER[w_hdr_lo +: 8];
      end
      StPayload: begin
        w_tx_en_d = 1'b1;
        if (w_cnt_d == 11'd0) begin
          w_txd_d = r_frames[15:8];
        end else if (w_cnt_d == 11'd1) begin
          w_txd_d = r_frames[7:0];
        end else begin
          w_txd_d = w_cnt_d[7:0];
        end
      end
      StPad: begin
        w_tx_en_d = 1'b1;
      end
      StFcs: begin
        // LSB-first register: its low byte is the first FCS byte on the wire.
        w_tx_en_d = 1'b1;
        w_txd_d   = ~w_crc_fcs[w_fcs_lo +: 8];
      end
      default: begin
      end
    endcase
  end

  // State, counter and frame count registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= 11'd0;
      r_frames <= 16'd0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_frames <= w_frames_d;
    end
  end

  // CRC accumulates data bytes, holds through FCS, and is re-seeded otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC_INIT;
    end else if (w_in_data) begin
      r_crc <= w_crc_next;
    end else if (r_state != StFcs) begin
      r_crc <= CRC_INIT;
    end
  end

  // Registered GMII outputs and busy flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_en <= 1'b0;
      r_txd   <= 8'h00;
      r_busy  <= 1'b0;
    end else begin
      r_tx_en <= w_tx_en_d;
      r_txd   <= w_txd_d;
      r_busy  <= (w_state_d != StIdle);
    end
  end

  assign bus.busy        = r_busy;
  assign bus.gmii_tx_en  = r_tx_en;
  assign bus.gmii_txd    = r_txd;
  assign bus.frames_sent = r_frames;

endmodule

// File: tb/tb_eth_gmii_frame_gen.sv
// Bench for eth_gmii_frame_gen: four instances with payload lengths 46, 2,
// 1500 and 10. Stimulus queues expected frame descriptors; a monitor rebuilds
// each expected frame from the framing rules and compares what appears on GMII.
module tb_eth_gmii_frame_gen;

  localparam int          NDUT = 4;
  localparam int          PL_TAB [NDUT] = '{46, 2, 1500, 10};
  localparam int          IFG = 12;
  localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC = 48'h0012_3456_789A;
  localparam logic [15:0] ETY = 16'h88B5;

  typedef struct {
    int seq;
    bit b2b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_r [NDUT];
  logic        cont_r  [NDUT];
  logic        busy_w  [NDUT];
  logic        tx_en_w [NDUT];
  logic [7:0]  txd_w   [NDUT];
  logic [15:0] fs_w    [NDUT];

  exp_t        exp_q [NDUT][$];
  logic [7:0]  rx_q  [NDUT][$];
  logic [7:0]  m_frame [$];
  logic [15:0] exp_cnt [NDUT];
  bit          abort   [NDUT];
  int          gap     [NDUT];
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #4 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    eth_gmii_frame_gen_if bus ();
    assign bus.start      = start_r[g];
    assign bus.continuous = cont_r[g];
    assign busy_w[g]      = bus.busy;
    assign tx_en_w[g]     = bus.gmii_tx_en;
    assign txd_w[g]       = bus.gmii_txd;
    assign fs_w[g]        = bus.frames_sent;

    eth_gmii_frame_gen #(
      .PAYLOAD_LEN (PL_TAB[g])
    ) u_dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // MSB-first CRC register, data bits taken LSB first (802.3 wire order).
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ b[i];
      c  = c << 1;
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  function automatic int tx_len(input int pl);
    return 8 + 14 + ((pl > 46) ? pl : 46) + 4;
  endfunction

  // Reference frame built directly from the framing rules.
  task automatic build_frame(input int pl, input int seq);
    logic [111:0] hdr;
    logic [111:0] t;
    logic [31:0]  c;
    logic [31:0] inv;
    m_frame.delete();
    repeat (7) m_frame.push_back(8'h55);
    m_frame.push_back(8'hD5);
    hdr = {DST, SRC, ETY};
    for (int i = 0; i < 14; i++) begin
      t = hdr >> (8 * (13 - i));
      m_frame.push_back(t[7:0]);
    end
    for (int i = 0; i < pl; i++) begin
      if (i == 0)      m_frame.push_back(8'((seq >> 8) & 255));
      else if (i == 1) m_frame.push_back(8'(seq & 255));
      else             m_frame.push_back(8'(i & 255));
    end
    for (int i = pl; i < 46; i++) m_frame.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < m_frame.size(); i++) c = crc_byte(c, m_frame[i]);
    inv = ~c;
    for (int k = 0; k < 4; k++) begin
      t = 112'(inv >> (24 - 8 * k));
      m_frame.push_back(rev8(t[7:0]));
    end
  endtask

  task automatic check_frame(input int d);
    exp_t        e;
    int          nmis;
    int          n;
    logic [31:0] rc;
    if (abort[d]) begin
      if (exp_q[d].size() > 0) e = exp_q[d].pop_front();
      abort[d] = 1'b0;
      return;
    end
    chk($sformatf("frame_expected_dut%0d", d), (exp_q[d].size() > 0), 1);
    if (exp_q[d].size() == 0) return;
    e = exp_q[d].pop_front();
    build_frame(PL_TAB[d], e.seq);
    chk($sformatf("frame_len_dut%0d_seq%0d", d, e.seq), rx_q[d].size(), m_frame.size());
    n = (rx_q[d].size() < m_frame.size()) ? rx_q[d].size() : m_frame.size();
    nmis = 0;
    for (int i = 0; i < n; i++) begin
      if (rx_q[d][i] !== m_frame[i]) begin
        if (nmis == 0) $display("first differing byte dut%0d idx %0d: got %02h want %02h",
                                d, i, rx_q[d][i], m_frame[i]);
        nmis++;
      end
    end
    chk($sformatf("frame_bytes_dut%0d_seq%0d_bad_bytes", d, e.seq), nmis, 0);
    rc = 32'hFFFF_FFFF;
    for (int i = 8; i < rx_q[d].size(); i++) rc = crc_byte(rc, rx_q[d][i]);
    chk($sformatf("fcs_residue_dut%0d", d), rc, 32'hC704_DD7B);
  endtask

  // Monitor: gathers bytes while tx_en is high, checks each finished frame.
  initial begin
    for (int d = 0; d < NDUT; d++) gap[d] = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (tx_en_w[d] === 1'b1) begin
          if (rx_q[d].size() == 0 && exp_q[d].size() > 0 && exp_q[d][0].b2b) begin
            chk($sformatf("ifg_gap_dut%0d", d), gap[d], IFG);
          end
          rx_q[d].push_back(txd_w[d]);
        end else begin
          chk($sformatf("idle_txd_zero_dut%0d", d), txd_w[d], 8'h00);
          if (rx_q[d].size() > 0) begin
            check_frame(d);
            rx_q[d].delete();
            gap[d] = 1;
          end else begin
            gap[d]++;
          end
        end
      end
    end
  end

  task automatic send_single(input int d, input bit poke);
    int n;
    int poke_at;
    poke_at = $urandom_range(0, 60);
    repeat ($urandom_range(1, 8)) @(posedge clk);
    #1;
    chk($sformatf("idle_before_start_dut%0d", d), tx_en_w[d], 1'b0);
    start_r[d] = 1'b1;
    exp_q[d].push_back('{seq: int'(exp_cnt[d]), b2b: 1'b0});
    @(posedge clk);
    #1;
    start_r[d] = 1'b0;
    chk($sformatf("start_latency_txen_dut%0d", d), tx_en_w[d], 1'b1);
    chk($sformatf("start_latency_txd_dut%0d", d), txd_w[d], 8'h55);
    chk($sformatf("start_latency_busy_dut%0d", d), busy_w[d], 1'b1);
    exp_cnt[d] = exp_cnt[d] + 16'd1;
    n = 0;
    while (busy_w[d] && n < 4000) begin
      start_r[d] = poke && (n == poke_at);
      @(posedge clk);
      #1;
      n++;
    end
    start_r[d] = 1'b0;
    chk($sformatf("busy_cycles_dut%0d", d), n, tx_len(PL_TAB[d]) + IFG);
    chk($sformatf("frames_sent_dut%0d", d), fs_w[d], exp_cnt[d]);
  endtask

  task automatic run_continuous(input int d);
    int n;
    int starts;
    int since;
    int drop_at;
    bit prev;
    drop_at = $urandom_range(0, 70);
    for (int k = 0; k < 3; k++) begin
      exp_q[d].push_back('{seq: int'(exp_cnt[d]) + k, b2b: (k != 0)});
    end
    @(posedge clk);
    #1;
    cont_r[d] = 1'b1;
    @(posedge clk);
    #1;
    chk("cont_start_latency", tx_en_w[d], 1'b1);
    n = 0;
    starts = 1;
    prev = 1'b1;
    since = 0;
    while (busy_w[d] && n < 2000) begin
      if (starts == 3) begin
        if (since == drop_at) cont_r[d] = 1'b0;
        since++;
      end
      @(posedge clk);
      #1;
      n++;
      if (tx_en_w[d] && !prev) starts++;
      prev = tx_en_w[d];
    end
    cont_r[d] = 1'b0;
    chk("cont_frame_count", starts, 3);
    chk("cont_busy_cycles", n, 3 * (tx_len(PL_TAB[d]) + IFG));
    exp_cnt[d] = exp_cnt[d] + 16'd3;
    chk("cont_frames_sent", fs_w[d], exp_cnt[d]);
  endtask

  task automatic reset_mid_frame();
    @(posedge clk);
    #1;
    start_r[0] = 1'b1;
    exp_q[0].push_back('{seq: int'(exp_cnt[0]), b2b: 1'b0});
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    // Wire index 42 is payload byte 20.
    repeat (42) @(posedge clk);
    #1;
    chk("byte_before_reset", txd_w[0], 8'h14);
    abort[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_txen", tx_en_w[0], 1'b0);
    chk("async_reset_txd", txd_w[0], 8'h00);
    chk("async_reset_busy", busy_w[0], 1'b0);
    chk("async_reset_frames", fs_w[0], 16'h0000);
    for (int d = 0; d < NDUT; d++) exp_cnt[d] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      start_r[d] = 1'b0;
      cont_r[d]  = 1'b0;
      exp_cnt[d] = 16'd0;
      abort[d]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_busy_dut%0d", d), busy_w[d], 1'b0);
      chk($sformatf("reset_txen_dut%0d", d), tx_en_w[d], 1'b0);
      chk($sformatf("reset_txd_dut%0d", d), txd_w[d], 8'h00);
      chk($sformatf("reset_frames_dut%0d", d), fs_w[d], 16'h0000);
    end
    rst_n = 1'b1;

    send_single(0, 1'b1);
    send_single(1, 1'b0);
    send_single(2, 1'b0);
    send_single(3, 1'b1);
    for (int k = 0; k < 4; k++) send_single(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    run_continuous(0);
    reset_mid_frame();
    send_single(0, 1'b0);

    repeat (60) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("leftover_expected_dut%0d", d), exp_q[d].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
